search_table_arbiter: RTL and testbench

Sequencing front end for the sorted key/data search table. Shares the single table port between `NUM_LK` lookup requesters and one maintenance requester (add/delete/update/clear), so only one transaction is ever in flight. Guards against table stalls with a timeout and pre-checks full/empty so illegal maintenance ops never reach the table.

---
 rtl/search_table_arbiter_pkg.sv | 28 ++
 rtl/search_table_arbiter_if.sv | 51 +++++
 rtl/search_table_arbiter_rr_arbiter.sv | 41 ++++
 rtl/search_table_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_search_table_arbiter.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/search_table_arbiter_pkg.sv
// Shared types and constants for the search table sequencing front end.
// Key/data widths, maintenance op codes, FSM states and the full/empty pre-check.
package search_table_pkg;

  localparam int KEY_W   = 16;
  localparam int DATA_W  = 16;
  localparam int COUNT_W = 11;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_DEL = 2'd1;
  localparam logic [1:0] OP_UPD = 2'd2;
  localparam logic [1:0] OP_CLR = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Maintenance ops that cannot succeed are rejected before touching the table.
  function automatic logic precheck_err(input logic [1:0]         code,
                                        input logic [COUNT_W-1:0] count,
                                        input logic [COUNT_W-1:0] depth);
    return ((code == OP_ADD) && (count == depth)) ||
           (((code == OP_DEL) || (code == OP_UPD)) && (count == '0));
  endfunction

endpackage

// File: rtl/search_table_arbiter_if.sv
// Client and table-side signal bundle of the search table arbiter.
// slave: the arbiter's view; master: requesters plus table.
interface search_table_arbiter_if #(
  parameter int NUM_LK = 4
);
  import search_table_pkg::*;

  logic [NUM_LK-1:0]       lk_req;
  logic [NUM_LK*KEY_W-1:0] lk_key;
  logic [NUM_LK-1:0]       lk_gnt;
  logic [NUM_LK-1:0]       lk_done;
  logic                    lk_found;
  logic [DATA_W-1:0]       lk_result;
  logic                    lk_err;

  logic                    op_req;
  logic [1:0]              op_code;
  logic [KEY_W-1:0]        op_key;
  logic [DATA_W-1:0]       op_data;
  logic                    op_gnt;
  logic                    op_done;
  logic                    op_err;

  logic                    tbl_req;
  logic                    tbl_op_req;
  logic [KEY_W-1:0]        tbl_key;
  logic [1:0]              tbl_op_code;
  logic [DATA_W-1:0]       tbl_op_data;
  logic                    tbl_done;
  logic                    tbl_found;
  logic [DATA_W-1:0]       tbl_result;
  logic                    tbl_op_err;
  logic [COUNT_W-1:0]      tbl_count;

  modport slave (
    input  lk_req, lk_key, op_req, op_code, op_key, op_data,
           tbl_done, tbl_found, tbl_result, tbl_op_err, tbl_count,
    output lk_gnt, lk_done, lk_found, lk_result, lk_err,
           op_gnt, op_done, op_err,
           tbl_req, tbl_op_req, tbl_key, tbl_op_code, tbl_op_data
  );

  modport master (
    output lk_req, lk_key, op_req, op_code, op_key, op_data,
           tbl_done, tbl_found, tbl_result, tbl_op_err, tbl_count,
    input  lk_gnt, lk_done, lk_found, lk_result, lk_err,
           op_gnt, op_done, op_err,
           tbl_req, tbl_op_req, tbl_key, tbl_op_code, tbl_op_data
  );

endinterface

// File: rtl/search_table_arbiter_rr_arbiter.sv
// Rotating-priority arbiter for the lookup clients: one-hot grant, search
// starts one past the last granted client, pointer moves only on adv.
module rr_arbiter #(
  parameter int NUM_LK = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_LK-1:0] req,
  input  logic              adv,
  output logic [NUM_LK-1:0] gnt
);

  localparam int PTR_W = (NUM_LK > 1) ? $clog2(NUM_LK) : 1;

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             found;
  int               idx;

  always_comb begin
    gnt   = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < NUM_LK; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NUM_LK) idx = idx - NUM_LK;
      if (!found && req[PTR_W'(idx)]) begin
        found                = 1'b1;
        gnt[PTR_W'(idx)]     = 1'b1;
        ptr_d                = (idx == NUM_LK - 1) ? '0 : PTR_W'(idx + 1);
      end
    end
    if (!adv) ptr_d = ptr_q;
  end

  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/search_table_arbiter.sv
// Single-port search table sequencer: arbitrates lookups against maintenance
// ops, pre-checks full/empty, and aborts table commands that never complete.
module search_table_arbiter
  import search_table_pkg::*;
#(
  parameter int NUM_LK       = 4,
  parameter int DEPTH        = 32,
  parameter int MAX_OP_BURST = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  search_table_arbiter_if.slave  bus
);

  localparam int TO_W     = $clog2(TIMEOUT + 1);
  localparam int STREAK_W = $clog2(MAX_OP_BURST + 1);

  state_e               state_q, state_d;
  logic [NUM_LK-1:0]    lk_gnt_q, lk_gnt_d;
  logic [NUM_LK-1:0]    lk_done_q, lk_done_d;
  logic [NUM_LK-1:0]    owner_lk_q, owner_lk_d;
  logic                 owner_op_q, owner_op_d;
  logic                 lk_found_q, lk_found_d;
  logic [DATA_W-1:0]    lk_result_q, lk_result_d;
  logic                 lk_err_q, lk_err_d;
  logic                 op_gnt_q, op_gnt_d;
  logic                 op_done_q, op_done_d;
  logic                 op_err_q, op_err_d;
  logic                 tbl_req_q, tbl_req_d;
  logic                 tbl_op_req_q, tbl_op_req_d;
  logic [KEY_W-1:0]     tbl_key_q, tbl_key_d;
  logic [1:0]           tbl_op_code_q, tbl_op_code_d;
  logic [DATA_W-1:0]    tbl_op_data_q, tbl_op_data_d;
  logic [TO_W-1:0]      to_cnt_q, to_cnt_d;
  logic [STREAK_W-1:0]  op_streak_q, op_streak_d;

  logic [NUM_LK-1:0]    rr_gnt;
  logic                 rr_adv;
  logic                 any_lk;
  logic                 op_wins;
  logic                 lk_wins;
  logic                 timed_out;
  logic [KEY_W-1:0]     sel_key;

  function automatic logic [STREAK_W-1:0] streak_inc(input logic [STREAK_W-1:0] s);
    return (s == STREAK_W'(MAX_OP_BURST)) ? s : s + STREAK_W'(1);
  endfunction

  assign any_lk    = |bus.lk_req;
  // Maintenance normally wins; a full burst yields one slot to a waiting lookup.
  assign op_wins   = bus.op_req && !((op_streak_q == STREAK_W'(MAX_OP_BURST)) && any_lk);
  assign lk_wins   = any_lk && !op_wins;
  assign rr_adv    = (state_q == ST_IDLE) && lk_wins;
  // BUSY lasts at most TIMEOUT+1 cycles; the counter is 0 in the grant cycle.
  assign timed_out = (to_cnt_q == TO_W'(TIMEOUT));

  rr_arbiter #(
    .NUM_LK (NUM_LK)
  ) u_rr (
    .clk   (clk),
    .reset (reset),
    .req   (bus.lk_req),
    .adv   (rr_adv),
    .gnt   (rr_gnt)
  );

  always_comb begin
    sel_key = '0;
    for (int i = 0; i < NUM_LK; i++) begin
      if (rr_gnt[i]) sel_key = bus.lk_key[i*KEY_W +: KEY_W];
    end
  end

  always_comb begin
    state_d       = state_q;
    lk_gnt_d      = '0;
    lk_done_d     = '0;
    lk_found_d    = 1'b0;
    lk_result_d   = '0;
    lk_err_d      = 1'b0;
    op_gnt_d      = 1'b0;
    op_done_d     = 1'b0;
    op_err_d      = 1'b0;
    owner_lk_d    = owner_lk_q;
    owner_op_d    = owner_op_q;
    tbl_req_d     = tbl_req_q;
    tbl_op_req_d  = tbl_op_req_q;
    tbl_key_d     = tbl_key_q;
    tbl_op_code_d = tbl_op_code_q;
    tbl_op_data_d = tbl_op_data_q;
    to_cnt_d      = to_cnt_q;
    op_streak_d   = op_streak_q;

    case (state_q)
      ST_IDLE: begin
        to_cnt_d = '0;
        if (op_wins) begin
          op_gnt_d      = 1'b1;
          owner_op_d    = 1'b1;
          owner_lk_d    = '0;
          op_streak_d   = streak_inc(op_streak_q);
          tbl_key_d     = bus.op_key;
          tbl_op_code_d = bus.op_code;
          tbl_op_data_d = bus.op_data;
          if (precheck_err(bus.op_code, bus.tbl_count, COUNT_W'(DEPTH))) begin
            op_done_d = 1'b1;
            op_err_d  = 1'b1;
            state_d   = ST_RESP;
          end else begin
            tbl_op_req_d = 1'b1;
            state_d      = ST_BUSY;
          end
        end else if (lk_wins) begin
          lk_gnt_d      = rr_gnt;
          owner_lk_d    = rr_gnt;
          owner_op_d    = 1'b0;
          op_streak_d   = '0;
          tbl_key_d     = sel_key;
          tbl_op_code_d = '0;
          tbl_op_data_d = '0;
          tbl_req_d     = 1'b1;
          state_d       = ST_BUSY;
        end
      end

      ST_BUSY: begin
        to_cnt_d = to_cnt_q + TO_W'(1);
        // A completion on the expiry cycle still counts as a good response.
        if (bus.tbl_done || timed_out) begin
          state_d      = ST_RESP;
          tbl_req_d    = 1'b0;
          tbl_op_req_d = 1'b0;
          if (owner_op_q) begin
            op_done_d = 1'b1;
            op_err_d  = !bus.tbl_done || bus.tbl_op_err;
          end else begin
            lk_done_d   = owner_lk_q;
            lk_err_d    = !bus.tbl_done;
            lk_found_d  = bus.tbl_done && bus.tbl_found;
            lk_result_d = lk_found_d ? bus.tbl_result : '0;
          end
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      lk_gnt_q      <= '0;
      lk_done_q     <= '0;
      owner_lk_q    <= '0;
      owner_op_q    <= 1'b0;
      lk_found_q    <= 1'b0;
      lk_result_q   <= '0;
      lk_err_q      <= 1'b0;
      op_gnt_q      <= 1'b0;
      op_done_q     <= 1'b0;
      op_err_q      <= 1'b0;
      tbl_req_q     <= 1'b0;
      tbl_op_req_q  <= 1'b0;
      tbl_key_q     <= '0;
      tbl_op_code_q <= '0;
      tbl_op_data_q <= '0;
      to_cnt_q      <= '0;
      op_streak_q   <= '0;
    end else begin
      state_q       <= state_d;
      lk_gnt_q      <= lk_gnt_d;
      lk_done_q     <= lk_done_d;
      owner_lk_q    <= owner_lk_d;
      owner_op_q    <= owner_op_d;
      lk_found_q    <= lk_found_d;
      lk_result_q   <= lk_result_d;
      lk_err_q      <= lk_err_d;
      op_gnt_q      <= op_gnt_d;
      op_done_q     <= op_done_d;
      op_err_q      <= op_err_d;
      tbl_req_q     <= tbl_req_d;
      tbl_op_req_q  <= tbl_op_req_d;
      tbl_key_q     <= tbl_key_d;
      tbl_op_code_q <= tbl_op_code_d;
      tbl_op_data_q <= tbl_op_data_d;
      to_cnt_q      <= to_cnt_d;
      op_streak_q   <= op_streak_d;
    end
  end

  assign bus.lk_gnt      = lk_gnt_q;
  assign bus.lk_done     = lk_done_q;
  assign bus.lk_found    = lk_found_q;
  assign bus.lk_result   = lk_result_q;
  assign bus.lk_err      = lk_err_q;
  assign bus.op_gnt      = op_gnt_q;
  assign bus.op_done     = op_done_q;
  assign bus.op_err      = op_err_q;
  assign bus.tbl_req     = tbl_req_q;
  assign bus.tbl_op_req  = tbl_op_req_q;
  assign bus.tbl_key     = tbl_key_q;
  assign bus.tbl_op_code = tbl_op_code_q;
  assign bus.tbl_op_data = tbl_op_data_q;

endmodule

// File: tb/tb_search_table_arbiter.sv
// Directed bench for search_table_arbiter: arbitration order, op burst limit,
// pre-check rejection, timeout handling and mid-transaction reset.
module tb_search_table_arbiter;

  localparam int NUM_LK  = 4;
  localparam int TIMEOUT = 64;

  logic clk;
  logic reset;
  int   checks;
  int   passes;
  logic stayed;

  search_table_arbiter_if #(.NUM_LK(NUM_LK)) bus ();

  search_table_arbiter #(
    .NUM_LK       (NUM_LK),
    .DEPTH        (32),
    .MAX_OP_BURST (4),
    .TIMEOUT      (TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    checks = 0;
    passes = 0;
    reset  = 1'b1;
    bus.lk_req     = '0;
    bus.lk_key     = '0;
    bus.op_req     = 1'b0;
    bus.op_code    = 2'd0;
    bus.op_key     = '0;
    bus.op_data    = '0;
    bus.tbl_done   = 1'b0;
    bus.tbl_found  = 1'b0;
    bus.tbl_result = '0;
    bus.tbl_op_err = 1'b0;
    bus.tbl_count  = 11'd5;
    tick();
    tick();

    // Reset state
    check("rst_lk_gnt",   32'(bus.lk_gnt), 0);
    check("rst_lk_done",  32'(bus.lk_done), 0);
    check("rst_op_gnt",   32'(bus.op_gnt), 0);
    check("rst_tbl_req",  32'(bus.tbl_req), 0);
    check("rst_tbl_opr",  32'(bus.tbl_op_req), 0);
    check("rst_tbl_key",  32'(bus.tbl_key), 0);

    // Round-robin with all lookup clients held, table misses
    reset = 1'b0;
    bus.lk_req = 4'b1111;
    for (int i = 0; i < NUM_LK; i++) bus.lk_key[16*i +: 16] = 16'(16'h0100 + i);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("rr_gnt",  32'(bus.lk_gnt), 32'(1 << (k % 4)));
      check("rr_key",  32'(bus.tbl_key), 32'(16'h0100 + (k % 4)));
      bus.tbl_done   = 1'b1;
      bus.tbl_found  = 1'b0;
      bus.tbl_result = 16'h1234;
      tick();
      check("rr_done",   32'(bus.lk_done), 32'(1 << (k % 4)));
      check("rr_result", 32'(bus.lk_result), 0);
      bus.tbl_done = 1'b0;
      tick();
      check("rr_idle_gnt", 32'(bus.lk_gnt), 0);
    end
    bus.lk_req = '0;

    // Single lookup: client 1, hit
    bus.lk_req = 4'b0010;
    bus.lk_key[31:16] = 16'h0025;
    tick();
    check("single_gnt",     32'(bus.lk_gnt), 'h2);
    check("single_tbl_req", 32'(bus.tbl_req), 1);
    check("single_tbl_opr", 32'(bus.tbl_op_req), 0);
    check("single_key",     32'(bus.tbl_key), 'h25);
    bus.lk_req     = '0;
    bus.tbl_done   = 1'b1;
    bus.tbl_found  = 1'b1;
    bus.tbl_result = 16'hBEEF;
    tick();
    check("single_done",   32'(bus.lk_done), 'h2);
    check("single_found",  32'(bus.lk_found), 1);
    check("single_result", 32'(bus.lk_result), 'hBEEF);
    check("single_err",    32'(bus.lk_err), 0);
    check("single_req_off", 32'(bus.tbl_req), 0);
    bus.tbl_done   = 1'b0;
    bus.tbl_found  = 1'b0;
    bus.tbl_result = '0;
    tick();
    check("single_done_off", 32'(bus.lk_done), 0);

    // Op burst limit: 4 ops, one lookup, ops resume
    bus.op_req  = 1'b1;
    bus.op_code = 2'd0;
    bus.op_key  = 16'h0042;
    bus.op_data = 16'h0D0D;
    bus.lk_req  = 4'b0001;
    bus.lk_key[15:0] = 16'h0077;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("burst_op_gnt", 32'(bus.op_gnt), (k == 4) ? 0 : 1);
      check("burst_lk_gnt", 32'(bus.lk_gnt), (k == 4) ? 1 : 0);
      check("burst_tbl_opr", 32'(bus.tbl_op_req), (k == 4) ? 0 : 1);
      bus.tbl_done   = 1'b1;
      bus.tbl_op_err = 1'b0;
      tick();
      check("burst_op_done", 32'(bus.op_done), (k == 4) ? 0 : 1);
      bus.tbl_done = 1'b0;
      tick();
    end
    bus.op_req = 1'b0;
    bus.lk_req = '0;

    // Pre-check: add into a full table
    bus.tbl_count = 11'd32;
    bus.op_code   = 2'd0;
    bus.op_req    = 1'b1;
    tick();
    check("pc_add_gnt",  32'(bus.op_gnt), 1);
    check("pc_add_done", 32'(bus.op_done), 1);
    check("pc_add_err",  32'(bus.op_err), 1);
    check("pc_add_opr",  32'(bus.tbl_op_req), 0);
    bus.op_req = 1'b0;
    tick();
    check("pc_add_opr2", 32'(bus.tbl_op_req), 0);

    // Pre-check: delete from an empty table
    bus.tbl_count = 11'd0;
    bus.op_code   = 2'd1;
    bus.op_req    = 1'b1;
    tick();
    check("pc_del_done", 32'(bus.op_done), 1);
    check("pc_del_err",  32'(bus.op_err), 1);
    check("pc_del_opr",  32'(bus.tbl_op_req), 0);
    bus.op_req = 1'b0;
    tick();

    // Clear on an empty table still goes to the table
    bus.op_code = 2'd3;
    bus.op_data = 16'hA5A5;
    bus.op_req  = 1'b1;
    tick();
    check("clr_gnt",  32'(bus.op_gnt), 1);
    check("clr_done_early", 32'(bus.op_done), 0);
    check("clr_opr",  32'(bus.tbl_op_req), 1);
    check("clr_code", 32'(bus.tbl_op_code), 3);
    check("clr_data", 32'(bus.tbl_op_data), 'hA5A5);
    bus.op_req     = 1'b0;
    bus.tbl_done   = 1'b1;
    bus.tbl_op_err = 1'b0;
    tick();
    check("clr_done", 32'(bus.op_done), 1);
    check("clr_err",  32'(bus.op_err), 0);
    bus.tbl_done  = 1'b0;
    bus.tbl_count = 11'd5;
    tick();

    // Timeout: table never answers
    bus.lk_req = 4'b0100;
    bus.lk_key[47:32] = 16'h3333;
    tick();
    check("to_gnt", 32'(bus.lk_gnt), 'h4);
    bus.lk_req     = '0;
    bus.tbl_found  = 1'b1;
    bus.tbl_result = 16'hDEAD;
    stayed = 1'b1;
    for (int i = 0; i < TIMEOUT; i++) begin
      tick();
      if (bus.lk_done !== 4'b0000 || bus.tbl_req !== 1'b1) stayed = 1'b0;
    end
    check("to_hold", 32'(stayed), 1);
    tick();
    check("to_done",   32'(bus.lk_done), 'h4);
    check("to_err",    32'(bus.lk_err), 1);
    check("to_result", 32'(bus.lk_result), 0);
    check("to_found",  32'(bus.lk_found), 0);
    check("to_req_off", 32'(bus.tbl_req), 0);
    tick();

    // Completion on the expiry cycle is not an error
    bus.lk_req = 4'b1000;
    tick();
    check("tx_gnt", 32'(bus.lk_gnt), 'h8);
    bus.lk_req = '0;
    stayed = 1'b1;
    for (int i = 0; i < TIMEOUT; i++) begin
      tick();
      if (bus.lk_done !== 4'b0000 || bus.tbl_req !== 1'b1) stayed = 1'b0;
    end
    check("tx_hold", 32'(stayed), 1);
    bus.tbl_done   = 1'b1;
    bus.tbl_found  = 1'b1;
    bus.tbl_result = 16'h4242;
    tick();
    check("tx_done",   32'(bus.lk_done), 'h8);
    check("tx_err",    32'(bus.lk_err), 0);
    check("tx_result", 32'(bus.lk_result), 'h4242);
    bus.tbl_done = 1'b0;
    tick();

    // Reset in the middle of a BUSY transaction
    bus.lk_req = 4'b0100;
    tick();
    check("mr_gnt", 32'(bus.lk_gnt), 'h4);
    bus.lk_req = '0;
    tick();
    reset = 1'b1;
    tick();
    check("mr_tbl_req", 32'(bus.tbl_req), 0);
    check("mr_lk_done", 32'(bus.lk_done), 0);
    check("mr_tbl_key", 32'(bus.tbl_key), 0);
    check("mr_lk_gnt",  32'(bus.lk_gnt), 0);
    reset = 1'b0;
    bus.lk_req = 4'b1111;
    tick();
    check("mr_fresh_gnt",  32'(bus.lk_gnt), 'h1);
    check("mr_no_done",    32'(bus.lk_done), 0);
    bus.lk_req     = '0;
    bus.tbl_done   = 1'b1;
    bus.tbl_found  = 1'b1;
    bus.tbl_result = 16'h0101;
    tick();
    check("mr_done",   32'(bus.lk_done), 'h1);
    check("mr_result", 32'(bus.lk_result), 'h0101);
    bus.tbl_done = 1'b0;
    tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
